// File: rtl/isp_blc.sv
// Black-level correction and per-channel linearization for raw Bayer data.
// Two-stage pipeline; configuration is shadowed at frame start, bypass until first frame.
module isp_blc #(
   parameter int BITS      = 12,
   parameter int GAIN_FRAC = 12
) (
   input  logic            pclk,
   input  logic            rst,
   input  logic [1:0]      bayer,
   input  logic            blc_en,
   input  logic            linear_en,
   input  logic [BITS-1:0] black_r,
   input  logic [BITS-1:0] black_gr,
   input  logic [BITS-1:0] black_gb,
   input  logic [BITS-1:0] black_b,
   input  logic [15:0]     gain_r,
   input  logic [15:0]     gain_gr,
   input  logic [15:0]     gain_gb,
   input  logic [15:0]     gain_b,
   input  logic            in_href,
   input  logic            in_vsync,
   input  logic [BITS-1:0] in_data,
   output logic            out_href,
   output logic            out_vsync,
   output logic [BITS-1:0] out_data
);

   localparam int PW = BITS + 16;
   localparam logic [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (GAIN_FRAC - 1);

   // Fixed-point gain with round-half-up and saturation to full scale.
   function automatic logic [BITS-1:0] apply_gain(input logic [BITS-1:0] d,
                                                  input logic [15:0]     g);
      logic [PW-1:0] prod;
      logic [PW-1:0] shr;
      prod = PW'(d) * PW'(g) + RND;
      shr  = prod >> GAIN_FRAC;
      if (|shr[PW-1:BITS]) begin
         apply_gain = {BITS{1'b1}};
      end else begin
         apply_gain = shr[BITS-1:0];
      end
   endfunction

   logic                      prev_vsync_q;
   logic                      prev_href_q;
   logic                      frame_start_s;
   logic                      line_end_s;
   logic                      armed_q, armed_d;
   logic                      col_par_q, col_par_d;
   logic                      row_par_q, row_par_d;
   logic                      row_cur_s;
   logic [1:0]                bayer_q, bayer_d;
   logic                      blc_en_q, blc_en_d;
   logic                      lin_en_q, lin_en_d;
   logic [3:0][BITS-1:0]      black_q, black_d, black_in_s;
   logic [3:0][15:0]          gain_q, gain_d, gain_in_s;
   logic [1:0]                chan_s;
   logic [BITS-1:0]           black_sel_s;
   logic [15:0]               gain_sel_s;
   logic [BITS-1:0]           s1_data_q, s1_data_d;
   logic [15:0]               s1_gain_q, s1_gain_d;
   logic                      s1_lin_q, s1_lin_d;
   logic                      s1_href_q;
   logic                      s1_vsync_q;
   logic [BITS-1:0]           out_data_q, out_data_d;
   logic                      out_href_q;
   logic                      out_vsync_q;

   assign black_in_s    = {black_b, black_gb, black_gr, black_r};
   assign gain_in_s     = {gain_b, gain_gb, gain_gr, gain_r};
   assign frame_start_s = prev_vsync_q & ~in_vsync;
   assign line_end_s    = prev_href_q & ~in_href;

   // Shadow configuration and armed flag; the _d values are what the current pixel sees.
   always_comb begin
      bayer_d  = bayer_q;
      blc_en_d = blc_en_q;
      lin_en_d = lin_en_q;
      black_d  = black_q;
      gain_d   = gain_q;
      if (frame_start_s) begin
         bayer_d  = bayer;
         blc_en_d = blc_en;
         lin_en_d = linear_en;
         black_d  = black_in_s;
         gain_d   = gain_in_s;
      end else begin
         bayer_d  = bayer_q;
         blc_en_d = blc_en_q;
         lin_en_d = lin_en_q;
         black_d  = black_q;
         gain_d   = gain_q;
      end
      armed_d = armed_q | frame_start_s;
   end

   // Bayer phase tracking; frame start overrides a coincident line end.
   always_comb begin
      col_par_d = 1'b0;
      row_par_d = row_par_q;
      row_cur_s = row_par_q;
      if (in_href) begin
         col_par_d = ~col_par_q;
      end else begin
         col_par_d = 1'b0;
      end
      if (frame_start_s) begin
         row_cur_s = 1'b0;
         row_par_d = 1'b0;
      end else if (line_end_s) begin
         row_cur_s = row_par_q;
         row_par_d = ~row_par_q;
      end else begin
         row_cur_s = row_par_q;
         row_par_d = row_par_q;
      end
   end

   assign chan_s      = {row_cur_s, col_par_q} ^ bayer_d;
   assign black_sel_s = black_d[chan_s];
   assign gain_sel_s  = gain_d[chan_s];

   // Stage 1: black-level subtraction clamped at zero.
   always_comb begin
      s1_data_d = in_data;
      if (armed_d && blc_en_d) begin
         if (in_data > black_sel_s) begin
            s1_data_d = in_data - black_sel_s;
         end else begin
            s1_data_d = {BITS{1'b0}};
         end
      end else begin
         s1_data_d = in_data;
      end
      s1_gain_d = gain_sel_s;
      s1_lin_d  = armed_d & lin_en_d;
   end

   // Stage 2: optional linearization gain, output blanked outside href.
   always_comb begin
      out_data_d = {BITS{1'b0}};
      if (!s1_href_q) begin
         out_data_d = {BITS{1'b0}};
      end else if (s1_lin_q) begin
         out_data_d = apply_gain(s1_data_q, s1_gain_q);
      end else begin
         out_data_d = s1_data_q;
      end
   end

   // State and pipeline registers.
   always_ff @(posedge pclk) begin
      if (rst) begin
         prev_vsync_q <= 1'b0;
         prev_href_q  <= 1'b0;
         armed_q      <= 1'b0;
         col_par_q    <= 1'b0;
         row_par_q    <= 1'b0;
         bayer_q      <= 2'b00;
         blc_en_q     <= 1'b0;
         lin_en_q     <= 1'b0;
         black_q      <= {(4*BITS){1'b0}};
         gain_q       <= {64{1'b0}};
         s1_data_q    <= {BITS{1'b0}};
         s1_gain_q    <= 16'h0000;
         s1_lin_q     <= 1'b0;
         s1_href_q    <= 1'b0;
         s1_vsync_q   <= 1'b0;
         out_data_q   <= {BITS{1'b0}};
         out_href_q   <= 1'b0;
         out_vsync_q  <= 1'b0;
      end else begin
         prev_vsync_q <= in_vsync;
         prev_href_q  <= in_href;
         armed_q      <= armed_d;
         col_par_q    <= col_par_d;
         row_par_q    <= row_par_d;
         bayer_q      <= bayer_d;
         blc_en_q     <= blc_en_d;
         lin_en_q     <= lin_en_d;
         black_q      <= black_d;
         gain_q       <= gain_d;
         s1_data_q    <= s1_data_d;
         s1_gain_q    <= s1_gain_d;
         s1_lin_q     <= s1_lin_d;
         s1_href_q    <= in_href;
         s1_vsync_q   <= in_vsync;
         out_data_q   <= out_data_d;
         out_href_q   <= s1_href_q;
         out_vsync_q  <= s1_vsync_q;
      end
   end

   assign out_href  = out_href_q;
   assign out_vsync = out_vsync_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_isp_blc.sv
// Directed self-checking bench for isp_blc: bypass, phase, clamp/gain, shadowing, reset, framing.
module tb_isp_blc;

   logic        pclk = 1'b0;
   logic        rst;
   logic [1:0]  bayer;
   logic        blc_en, linear_en;
   logic [11:0] black_r, black_gr, black_gb, black_b;
   logic [15:0] gain_r, gain_gr, gain_gb, gain_b;
   logic        in_href, in_vsync;
   logic [11:0] in_data;
   logic        out_href, out_vsync;
   logic [11:0] out_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pc[$];

   logic        ih_log [4096];
   logic        iv_log [4096];
   logic        oh_log [4096];
   logic        ov_log [4096];
   logic [11:0] od_log [4096];

   isp_blc #(.BITS(12), .GAIN_FRAC(12)) dut (
      .pclk(pclk), .rst(rst), .bayer(bayer), .blc_en(blc_en), .linear_en(linear_en),
      .black_r(black_r), .black_gr(black_gr), .black_gb(black_gb), .black_b(black_b),
      .gain_r(gain_r), .gain_gr(gain_gr), .gain_gb(gain_gb), .gain_b(gain_b),
      .in_href(in_href), .in_vsync(in_vsync), .in_data(in_data),
      .out_href(out_href), .out_vsync(out_vsync), .out_data(out_data)
   );

   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc <= cyc + 1;

   // Log inputs and outputs mid-cycle, indexed by cycle number.
   always @(negedge pclk) begin
      ih_log[cyc & 4095] <= in_href;
      iv_log[cyc & 4095] <= in_vsync;
      oh_log[cyc & 4095] <= out_href;
      ov_log[cyc & 4095] <= out_vsync;
      od_log[cyc & 4095] <= out_data;
   end

   function automatic int ix(input int c);
      return c & 4095;
   endfunction

   task automatic cfg(input logic [1:0] b, input logic be, input logic le,
                      input logic [11:0] br, input logic [11:0] bgr,
                      input logic [11:0] bgb, input logic [11:0] bb, input logic [15:0] g);
      bayer = b; blc_en = be; linear_en = le;
      black_r = br; black_gr = bgr; black_gb = bgb; black_b = bb;
      gain_r = g; gain_gr = g; gain_gb = g; gain_b = g;
   endtask

   task automatic px(input logic h, input logic v, input logic [11:0] d);
      in_href = h; in_vsync = v; in_data = d;
      if (h) pc.push_back(cyc);
      @(posedge pclk);
      #1;
   endtask

   task automatic line(input int n, input logic [11:0] d);
      for (int i = 0; i < n; i++) px(1'b1, 1'b0, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) px(1'b0, 1'b0, 12'h5A5);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_href = 1'b1; in_vsync = 1'b1; in_data = 12'hFFF;
      cfg(2'd0, 1'b1, 1'b0, 12'd10, 12'd10, 12'd10, 12'd10, 16'd4096);
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      checks++;
      if (out_href !== 1'b0) begin errors++; $display("FAIL reset_href: got %b expected 0", out_href); end
      checks++;
      if (out_vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b expected 0", out_vsync); end
      checks++;
      if (out_data !== 12'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", out_data); end
      @(posedge pclk);
      #1;
      rst = 1'b0; in_href = 1'b0; in_vsync = 1'b0; in_data = 12'd0;
      pc.delete();
      idle(1);
      px(1'b1, 1'b0, 12'd100); px(1'b1, 1'b0, 12'd200);
      px(1'b1, 1'b0, 12'd300); px(1'b1, 1'b0, 12'd4095);
      idle(4);
      begin
         int ex [4] = '{100, 200, 300, 4095};
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (od_log[ix(pc[k] + 2)] !== 12'(ex[k])) begin
               errors++;
               $display("FAIL unarmed_bypass px%0d: got %0d expected %0d", k, od_log[ix(pc[k] + 2)], ex[k]);
            end
         end
      end
   endtask

   task automatic test_passthrough();
      int t0, t1;
      cfg(2'd0, 1'b0, 1'b0, 12'd10, 12'd10, 12'd10, 12'd10, 16'd0);
      pc.delete();
      t0 = cyc;
      px(1'b0, 1'b1, 12'h5A5);
      idle(2);
      for (int i = 0; i < 16; i++) px(1'b1, 1'b0, 12'(i));
      idle(3);
      t1 = cyc;
      idle(3);
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (od_log[ix(pc[k] + 2)] !== 12'(k)) begin
            errors++;
            $display("FAIL pass_ramp px%0d: got %0d expected %0d", k, od_log[ix(pc[k] + 2)], k);
         end
      end
      for (int c = t0; c < t1; c++) begin
         checks++;
         if (oh_log[ix(c + 2)] !== ih_log[ix(c)]) begin
            errors++;
            $display("FAIL pass_href cyc%0d: got %b expected %b", c + 2, oh_log[ix(c + 2)], ih_log[ix(c)]);
         end
         checks++;
         if (ov_log[ix(c + 2)] !== iv_log[ix(c)]) begin
            errors++;
            $display("FAIL pass_vsync cyc%0d: got %b expected %b", c + 2, ov_log[ix(c + 2)], iv_log[ix(c)]);
         end
         if (!ih_log[ix(c)]) begin
            checks++;
            if (od_log[ix(c + 2)] !== 12'd0) begin
               errors++;
               $display("FAIL pass_blank cyc%0d: got %0d expected 0", c + 2, od_log[ix(c + 2)]);
            end
         end
      end
   endtask

   task automatic test_bayer(input logic [1:0] b, input int e0, input int e1, input int e2,
                             input int e3, input int e4, input int e5, input int e6, input int e7);
      int ex [8];
      ex = '{e0, e1, e2, e3, e4, e5, e6, e7};
      cfg(b, 1'b1, 1'b0, 12'd10, 12'd20, 12'd30, 12'd40, 16'd4096);
      pc.delete();
      px(1'b0, 1'b1, 12'd0);
      idle(1);
      line(4, 12'd100);
      idle(1);
      line(4, 12'd100);
      idle(3);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (od_log[ix(pc[k] + 2)] !== 12'(ex[k])) begin
            errors++;
            $display("FAIL bayer%0d px%0d: got %0d expected %0d", b, k, od_log[ix(pc[k] + 2)], ex[k]);
         end
      end
   endtask

   task automatic test_linear();
      int t_blk  [7] = '{64, 64, 0, 64, 0, 0, 0};
      int t_gain [7] = '{4096, 4096, 6144, 8192, 0, 65535, 6144};
      int t_in   [7] = '{100, 50, 3, 4095, 4095, 4095, 1};
      int t_exp  [7] = '{36, 0, 5, 4095, 0, 4095, 2};
      for (int n = 0; n < 7; n++) begin
         cfg(2'd0, 1'b1, 1'b1, 12'(t_blk[n]), 12'(t_blk[n]), 12'(t_blk[n]), 12'(t_blk[n]),
             16'(t_gain[n]));
         pc.delete();
         px(1'b0, 1'b1, 12'd0);
         idle(1);
         line(4, 12'(t_in[n]));
         idle(3);
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (od_log[ix(pc[k] + 2)] !== 12'(t_exp[n])) begin
               errors++;
               $display("FAIL linear case%0d px%0d: got %0d expected %0d", n, k,
                        od_log[ix(pc[k] + 2)], t_exp[n]);
            end
         end
      end
   endtask

   task automatic test_shadow();
      int ex [12] = '{90, 100, 90, 100, 90, 100, 90, 100, 50, 100, 50, 100};
      cfg(2'd0, 1'b1, 1'b0, 12'd10, 12'd0, 12'd0, 12'd0, 16'd4096);
      pc.delete();
      px(1'b0, 1'b1, 12'd0);
      idle(1);
      line(2, 12'd100);
      black_r = 12'd50;
      line(6, 12'd100);
      idle(1);
      black_r = 12'd10;
      px(1'b0, 1'b1, 12'd0);
      black_r = 12'd50;
      px(1'b1, 1'b0, 12'd100);
      black_r = 12'd10;
      line(3, 12'd100);
      idle(3);
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (od_log[ix(pc[k] + 2)] !== 12'(ex[k])) begin
            errors++;
            $display("FAIL shadow px%0d: got %0d expected %0d", k, od_log[ix(pc[k] + 2)], ex[k]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int rc;
      int ex [16] = '{90, 80, -1, -1, 100, 100, 100, 100, 100, 100, 100, 100, 90, 80, 90, 80};
      cfg(2'd0, 1'b1, 1'b0, 12'd10, 12'd20, 12'd30, 12'd40, 16'd4096);
      pc.delete();
      px(1'b0, 1'b1, 12'd0);
      idle(1);
      line(3, 12'd100);
      rst = 1'b1;
      rc  = cyc;
      px(1'b1, 1'b0, 12'd100);
      rst = 1'b0;
      line(4, 12'd100);
      idle(1);
      line(4, 12'd100);
      idle(1);
      px(1'b0, 1'b1, 12'd0);
      idle(1);
      line(4, 12'd100);
      idle(3);
      checks++;
      if (oh_log[ix(rc + 1)] !== 1'b0) begin
         errors++; $display("FAIL midrst_href: got %b expected 0", oh_log[ix(rc + 1)]);
      end
      checks++;
      if (od_log[ix(rc + 1)] !== 12'd0) begin
         errors++; $display("FAIL midrst_data: got %0d expected 0", od_log[ix(rc + 1)]);
      end
      for (int k = 0; k < 16; k++) begin
         if (ex[k] >= 0) begin
            checks++;
            if (od_log[ix(pc[k] + 2)] !== 12'(ex[k])) begin
               errors++;
               $display("FAIL midrst px%0d: got %0d expected %0d", k, od_log[ix(pc[k] + 2)], ex[k]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int t0, t1, n_in, n_out;
      cfg(2'd0, 1'b1, 1'b0, 12'd10, 12'd20, 12'd30, 12'd40, 16'd4096);
      pc.delete();
      t0 = cyc;
      px(1'b0, 1'b1, 12'd0);
      for (int f = 0; f < 2; f++) begin
         for (int l = 0; l < 3; l++) begin
            line(4, 12'd100);
            if (l == 2 && f == 0) px(1'b0, 1'b1, 12'h5A5);
            else px(1'b0, 1'b0, 12'h5A5);
         end
      end
      idle(2);
      t1 = cyc;
      idle(3);
      for (int k = 0; k < 24; k++) begin
         int row, col, e;
         row = (k / 4) % 3;
         col = k % 4;
         e = (row % 2 == 0) ? ((col % 2 == 0) ? 90 : 80) : ((col % 2 == 0) ? 70 : 60);
         checks++;
         if (od_log[ix(pc[k] + 2)] !== 12'(e)) begin
            errors++;
            $display("FAIL b2b px%0d: got %0d expected %0d", k, od_log[ix(pc[k] + 2)], e);
         end
      end
      n_in = 0;
      n_out = 0;
      for (int c = t0; c < t1; c++) begin
         if (ih_log[ix(c)]) n_in++;
         if (oh_log[ix(c + 2)]) n_out++;
         checks++;
         if (ov_log[ix(c + 2)] !== iv_log[ix(c)]) begin
            errors++;
            $display("FAIL b2b_vsync cyc%0d: got %b expected %b", c + 2, ov_log[ix(c + 2)], iv_log[ix(c)]);
         end
      end
      checks++;
      if (n_in !== 24) begin errors++; $display("FAIL b2b_in_count: got %0d expected 24", n_in); end
      checks++;
      if (n_out !== 24) begin errors++; $display("FAIL b2b_out_count: got %0d expected 24", n_out); end
   endtask

   initial begin
      rst = 1'b1;
      in_href = 1'b0; in_vsync = 1'b0; in_data = 12'd0;
      cfg(2'd0, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 12'd0, 16'd0);
      test_reset();
      test_passthrough();
      test_bayer(2'd0, 90, 80, 90, 80, 70, 60, 70, 60);
      test_bayer(2'd3, 60, 70, 60, 70, 80, 90, 80, 90);
      test_linear();
      test_shadow();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
